online_div_residue_seq: RTL and testbench

Sequencer for the online-division residue storage (V fractional-bit buffer).
- Per quotient digit iteration, walks the residue word address space and drives the storage's enable/new_line/addr.
- Waits for the digit-selection stage, then advances the digit counter, honouring the online delay.
- Sits between the divider top-level control and the residue buffer plus the digit-selection logic.

---
 rtl/online_div_residue_seq.sv | 148 ++++++++++++++
 tb/tb_online_div_residue_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_div_residue_seq.sv
// Residue-buffer sequencer for online division: walks the residue words once per digit iteration.
// Optional ONLINE_DIV_RES_CLEAR_EN adds a CLEAR sweep of the whole buffer after each accepted start.
module online_div_residue_seq #(
    parameter int ADDR_WIDTH   = 7,
    parameter int ONLINE_DELAY = 4,
    parameter int DIGIT_W      = 8
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                start,
    input  logic                abort,
    input  logic [DIGIT_W-1:0]  cfg_digits,
    input  logic [ADDR_WIDTH:0] cfg_words,
    input  logic                dp_ready,
    input  logic                sel_done,
    output logic                enable,
    output logic                new_line,
    output logic [10:0]         addr,
    output logic [DIGIT_W-1:0]  digit_idx,
    output logic                q_valid,
    output logic                busy,
    output logic                done,
    output logic                clr
);

`ifdef ONLINE_DIV_RES_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WALK, S_SELECT, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_WALK, S_SELECT, S_DONE} state_e;
`endif

    localparam logic [ADDR_WIDTH:0]   WORDS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   WORDS_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIGIT_W:0]      ITER_ONE  = {{DIGIT_W{1'b0}}, 1'b1};
    localparam logic [DIGIT_W:0]      DELAY     = (DIGIT_W+1)'(ONLINE_DELAY);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // Iteration counter carries one extra bit so cfg_digits + delay never wraps.
    logic [DIGIT_W:0]      iter_q, iter_d;
    logic [DIGIT_W:0]      total_q, total_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  last_word, last_iter;

    assign last_word = ({1'b0, addr_q} == (words_q - WORDS_ONE));
    assign last_iter = (iter_q == (total_q - ITER_ONE));

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        iter_d  = iter_q;
        total_d = total_q;
        words_d = words_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d = {1'b0, cfg_digits} + DELAY;
                    if (cfg_words == '0)
                        words_d = WORDS_ONE;
                    else if (cfg_words > WORDS_MAX)
                        words_d = WORDS_MAX;
                    else
                        words_d = cfg_words;
                    addr_d  = '0;
                    iter_d  = '0;
`ifdef ONLINE_DIV_RES_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_WALK;
`endif
                end
            end
`ifdef ONLINE_DIV_RES_CLEAR_EN
            S_CLEAR: begin
                addr_d = addr_q + ADDR_ONE;
                if (&addr_q)
                    state_d = S_WALK;
            end
`endif
            S_WALK: begin
                if (dp_ready) begin
                    if (last_word) begin
                        addr_d  = '0;
                        state_d = S_SELECT;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end
            end
            S_SELECT: begin
                if (sel_done) begin
                    if (last_iter) begin
                        state_d = S_DONE;
                    end else begin
                        iter_d  = iter_q + ITER_ONE;
                        state_d = S_WALK;
                    end
                end
            end
            S_DONE: begin
                iter_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever transition the case above chose.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = '0;
            iter_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            iter_q  <= '0;
            total_q <= '0;
            words_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            iter_q  <= iter_d;
            total_q <= total_d;
            words_q <= words_d;
        end
    end

    assign enable    = (state_q == S_WALK) && dp_ready;
    assign new_line  = enable && (addr_q == '0);
    assign addr      = {{(11-ADDR_WIDTH){1'b0}}, addr_q};
    assign digit_idx = iter_q[DIGIT_W-1:0];
    assign q_valid   = (state_q == S_SELECT) && sel_done && !abort && (iter_q >= DELAY);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE) && !abort;
`ifdef ONLINE_DIV_RES_CLEAR_EN
    assign clr       = (state_q == S_CLEAR);
`else
    assign clr       = 1'b0;
`endif

endmodule

// File: tb/tb_online_div_residue_seq.sv
// Self-checking bench for online_div_residue_seq: per-cycle behavioural model plus directed literal checks.
module tb_online_div_residue_seq;
    localparam int AW     = 7;
    localparam int DELAY  = 4;
    localparam int DW     = 8;
    localparam int NWORDS = 1 << AW;
`ifdef ONLINE_DIV_RES_CLEAR_EN
    localparam int CLR_CYC = NWORDS;
`else
    localparam int CLR_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          asyn_reset, start, abort, dp_ready, sel_done;
    logic [DW-1:0] cfg_digits;
    logic [AW:0]   cfg_words;
    logic          enable, new_line, q_valid, busy, done, clr;
    logic [10:0]   addr;
    logic [DW-1:0] digit_idx;

    online_div_residue_seq #(.ADDR_WIDTH(AW), .ONLINE_DELAY(DELAY), .DIGIT_W(DW)) dut (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .abort(abort),
        .cfg_digits(cfg_digits), .cfg_words(cfg_words), .dp_ready(dp_ready), .sel_done(sel_done),
        .enable(enable), .new_line(new_line), .addr(addr), .digit_idx(digit_idx),
        .q_valid(q_valid), .busy(busy), .done(done), .clr(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_words(input int w);
        if (w < 1) return 1;
        if (w > NWORDS) return NWORDS;
        return w;
    endfunction

    // Behavioural model: phase of the division, current word, iteration, run parameters.
    localparam int M_IDLE = 0, M_CLEAR = 1, M_WALK = 2, M_SEL = 3, M_FIN = 4;
    int m_phase = M_IDLE;
    int m_word  = 0;
    int m_iter  = 0;
    int m_total = 0;
    int m_words = 1;

    always @(negedge clk) begin
        int e_en, e_nl, e_addr, e_dig, e_qv, e_busy, e_done, e_clr;
        if (asyn_reset) begin
            e_en = 0; e_nl = 0; e_addr = 0; e_dig = 0; e_qv = 0; e_busy = 0; e_done = 0; e_clr = 0;
        end else begin
            e_en   = (m_phase == M_WALK && dp_ready) ? 1 : 0;
            e_nl   = (e_en == 1 && m_word == 0) ? 1 : 0;
            e_addr = m_word;
            e_dig  = m_iter;
            e_qv   = (m_phase == M_SEL && sel_done && !abort && m_iter >= DELAY) ? 1 : 0;
            e_busy = (m_phase == M_CLEAR || m_phase == M_WALK || m_phase == M_SEL) ? 1 : 0;
            e_done = (m_phase == M_FIN && !abort) ? 1 : 0;
            e_clr  = (m_phase == M_CLEAR) ? 1 : 0;
        end
        check("enable", enable, e_en);
        check("new_line", new_line, e_nl);
        check("addr", addr, e_addr);
        check("digit_idx", digit_idx, e_dig);
        check("q_valid", q_valid, e_qv);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("clr", clr, e_clr);

        if (asyn_reset || (abort && m_phase != M_IDLE)) begin
            m_phase = M_IDLE; m_word = 0; m_iter = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_total = int'(cfg_digits) + DELAY;
                    m_words = clamp_words(int'(cfg_words));
                    m_word  = 0;
                    m_iter  = 0;
                    m_phase = (CLR_CYC > 0) ? M_CLEAR : M_WALK;
                end
                M_CLEAR: begin
                    m_word++;
                    if (m_word == NWORDS) begin m_word = 0; m_phase = M_WALK; end
                end
                M_WALK: if (dp_ready) begin
                    m_word++;
                    if (m_word == m_words) begin m_word = 0; m_phase = M_SEL; end
                end
                M_SEL: if (sel_done) begin
                    if (m_iter == m_total - 1) m_phase = M_FIN;
                    else begin m_iter++; m_phase = M_WALK; end
                end
                default: begin m_phase = M_IDLE; m_iter = 0; end
            endcase
        end
    end

    // Results of the last run_fixed call.
    int r_lat, r_qv, r_en, r_nl, r_max, r_clr, r_first;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a division and observes it until done, counting output events.
    task automatic run_fixed(input int digits, input int words);
        cfg_digits = DW'(digits);
        cfg_words  = (AW+1)'(words);
        start = 1'b1;
        @(negedge clk);
        step();
        start = 1'b0;
        r_lat = -1; r_qv = 0; r_en = 0; r_nl = 0; r_max = 0; r_clr = 0; r_first = -1;
        for (int c = 1; c < 3000 && r_lat < 0; c++) begin
            @(negedge clk);
            if (enable) begin
                r_en++;
                if (r_first < 0) begin
                    r_first = c;
                    check("first_en_addr", addr, 0);
                    check("first_en_new_line", new_line, 1);
                end
                if (int'(addr) > r_max) r_max = int'(addr);
            end
            if (new_line) r_nl++;
            if (q_valid) r_qv++;
            if (clr) r_clr++;
            if (done) begin
                r_lat = c;
                check("busy_at_done", busy, 0);
            end
        end
        if (r_lat < 0) check("run_timeout", 0, 1);
        step();
    endtask

    task automatic wait_done(input string name);
        int seen = 0;
        for (int c = 0; c < 3000 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(name, seen, 1);
        step();
    endtask

    initial begin
        asyn_reset = 1'b1; start = 1'b0; abort = 1'b0; dp_ready = 1'b1; sel_done = 1'b1;
        cfg_digits = '0; cfg_words = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_addr", addr, 0);
        check("reset_enable", enable, 0);
        step();
        asyn_reset = 1'b0;
        step();

        // Basic run: 3 digits, 4 words, 7 iterations of 5 cycles each.
        run_fixed(3, 4);
        check("t1_latency", r_lat, 36 + CLR_CYC);
        check("t1_q_valid_count", r_qv, 3);
        check("t1_enable_count", r_en, 28);
        check("t1_new_line_count", r_nl, 7);
        check("t1_max_addr", r_max, 3);
        check("t1_clr_cycles", r_clr, CLR_CYC);
        check("t1_first_enable", r_first, CLR_CYC + 1);

        // Stall with addr at 2.
        cfg_digits = '0; cfg_words = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (CLR_CYC + 2) @(posedge clk);
        #1;
        dp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", addr, 2);
            check("stall_enable", enable, 0);
            step();
        end
        dp_ready = 1'b1;
        @(negedge clk);
        check("resume_addr", addr, 2);
        check("resume_enable", enable, 1);
        step();
        wait_done("t2_done");

        // Word-count clamping at both ends.
        run_fixed(1, 0);
        check("t3a_latency", r_lat, 11 + CLR_CYC);
        check("t3a_enable_count", r_en, 5);
        check("t3a_new_line_count", r_nl, 5);
        check("t3a_max_addr", r_max, 0);
        check("t3a_q_valid_count", r_qv, 1);
        run_fixed(0, 200);
        check("t3b_latency", r_lat, 517 + CLR_CYC);
        check("t3b_enable_count", r_en, 512);
        check("t3b_max_addr", r_max, NWORDS - 1);
        check("t3b_q_valid_count", r_qv, 0);

        // Abort in SELECT of iteration 5 with sel_done high.
        cfg_digits = 8'd3; cfg_words = 5'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int found = 0;
            for (int c = 0; c < 3000 && found == 0; c++) begin
                @(negedge clk);
                if (digit_idx == 8'd5 && enable && addr == 11'd1) found = 1;
            end
            check("t4_reach_iter5", found, 1);
        end
        step();
        abort = 1'b1;
        @(negedge clk);
        check("t4_in_select_digit", digit_idx, 5);
        check("t4_abort_q_valid", q_valid, 0);
        check("t4_abort_done", done, 0);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("t4_after_busy", busy, 0);
        check("t4_after_digit", digit_idx, 0);
        step();
        run_fixed(1, 3);
        check("t4_rerun_latency", r_lat, 21 + CLR_CYC);
        check("t4_rerun_q_valid", r_qv, 1);

        // start while busy and in the DONE cycle.
        cfg_digits = '0; cfg_words = 5'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6 + CLR_CYC) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        check("t5_done_cycle", done, 1);
        step();
        start = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_digit", digit_idx, 0);
        step();

        // Reset in the middle of a walk.
        cfg_digits = 8'd2; cfg_words = 5'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3 + CLR_CYC) @(posedge clk);
        #1;
        check("t5_walking", enable, 1);
        asyn_reset = 1'b1;
        #1;
        check("t5_rst_enable", enable, 0);
        check("t5_rst_addr", addr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_new_line", new_line, 0);
        step();
        asyn_reset = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int c = 0; c < 12000; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 199) == 0);
            dp_ready   = ($urandom_range(0, 3) != 0);
            sel_done   = $urandom_range(0, 1) == 1;
            cfg_digits = DW'($urandom_range(0, 5));
            cfg_words  = ($urandom_range(0, 7) == 0) ? (AW+1)'($urandom) : (AW+1)'($urandom_range(0, 9));
            asyn_reset = ($urandom_range(0, 2999) == 0);
            step();
        end

        start = 1'b0; abort = 1'b0; asyn_reset = 1'b0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
